// File: rtl/text_cmd_engine_if.sv
// CPU register port and text-memory write port of the text command engine.
interface text_cmd_engine_if #(
    parameter int unsigned ADDR_W = 12
);
    logic              ce;
    logic              rw;
    logic [3:0]        addr;
    logic [7:0]        data_in;
    logic [7:0]        data_out;
    logic [ADDR_W-1:0] text_addr;
    logic [15:0]       text_data;
    logic              text_enable;
    logic              text_ready;

    // Engine side
    modport slave (
        input  ce, rw, addr, data_in, text_ready,
        output data_out, text_addr, text_data, text_enable
    );

    // Host CPU / text memory side
    modport master (
        output ce, rw, addr, data_in, text_ready,
        input  data_out, text_addr, text_data, text_enable
    );
endinterface

// File: rtl/text_cmd_engine.sv
// Byte-wide CPU register port -> 16-bit text memory writes, with write FIFO,
// cursor auto-advance and a clear-screen / clear-to-EOL fill engine.
module text_cmd_engine #(
    parameter int unsigned COLS       = 80,
    parameter int unsigned ROWS       = 30,
    parameter int unsigned ADDR_W     = 12,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic               cpu_clock,
    input  logic               reset,
    text_cmd_engine_if.slave   bus
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = ADDR_W + 1;

    localparam logic [7:0]        COLS_M1      = 8'(COLS - 1);
    localparam logic [7:0]        ROWS_M1      = 8'(ROWS - 1);
    localparam logic [CNT_W-1:0]  SCREEN_WORDS = CNT_W'(COLS * ROWS);
    localparam logic [CNT_W-1:0]  CNT_ONE      = CNT_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE     = ADDR_W'(1);
    localparam logic [PTR_W:0]    PTR_ONE      = (PTR_W + 1)'(1);

    localparam logic [3:0] REG_ATTR     = 4'd0;
    localparam logic [3:0] REG_CHAR     = 4'd1;
    localparam logic [3:0] REG_FILLCHAR = 4'd2;
    localparam logic [3:0] REG_CUR_X    = 4'd3;
    localparam logic [3:0] REG_CUR_Y    = 4'd4;
    localparam logic [3:0] REG_CMD      = 4'd5;
    localparam logic [3:0] REG_STATUS   = 4'd6;

    localparam logic [7:0] CMD_CLEAR = 8'h01;
    localparam logic [7:0] CMD_EOL   = 8'h02;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_FILL
    } state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [15:0]       data;
    } entry_t;

    state_e            state_q, state_d;
    logic [7:0]        attr_q, attr_d;
    logic [7:0]        char_q, char_d;
    logic [7:0]        fillchar_q, fillchar_d;
    logic [7:0]        cur_x_q, cur_x_d;
    logic [7:0]        cur_y_q, cur_y_d;
    logic              overflow_q, overflow_d;
    logic [7:0]        data_out_q, data_out_d;
    logic [ADDR_W-1:0] text_addr_q, text_addr_d;
    logic [15:0]       text_data_q, text_data_d;
    logic              text_enable_q, text_enable_d;
    logic              slot_fifo_q, slot_fifo_d;
    logic [ADDR_W-1:0] fill_addr_q, fill_addr_d;
    logic [CNT_W-1:0]  fill_left_q, fill_left_d;
    logic [15:0]       fill_word_q, fill_word_d;
    logic [PTR_W:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]    rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    ld_ptr_q, ld_ptr_d;
    entry_t            fifo_q [FIFO_DEPTH];
    entry_t            fifo_d [FIFO_DEPTH];

    logic              wr_access;
    logic              rd_access;
    logic              cmd_valid;
    logic              slot_free;
    logic              pop;
    logic              can_load;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push_ok;
    logic [ADDR_W-1:0] cursor_addr;
    entry_t            head;

    assign bus.data_out    = data_out_q;
    assign bus.text_addr   = text_addr_q;
    assign bus.text_data   = text_data_q;
    assign bus.text_enable = text_enable_q;

    // Next-state: output slot / fill sequencing, FIFO pointers, register file
    always_comb begin
        state_d       = state_q;
        attr_d        = attr_q;
        char_d        = char_q;
        fillchar_d    = fillchar_q;
        cur_x_d       = cur_x_q;
        cur_y_d       = cur_y_q;
        overflow_d    = overflow_q;
        data_out_d    = data_out_q;
        text_addr_d   = text_addr_q;
        text_data_d   = text_data_q;
        text_enable_d = text_enable_q;
        slot_fifo_d   = slot_fifo_q;
        fill_addr_d   = fill_addr_q;
        fill_left_d   = fill_left_q;
        fill_word_d   = fill_word_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        ld_ptr_d      = ld_ptr_q;
        fifo_d        = fifo_q;

        wr_access   = bus.ce && bus.rw;
        rd_access   = bus.ce && !bus.rw;
        cmd_valid   = wr_access && (bus.addr == REG_CMD) && (state_q != ST_FILL)
                      && ((bus.data_in == CMD_CLEAR) || (bus.data_in == CMD_EOL));
        cursor_addr = ADDR_W'(cur_y_q) * ADDR_W'(COLS) + ADDR_W'(cur_x_q);

        // FIFO space is freed only when a FIFO-sourced word actually transfers;
        // ld_ptr runs one ahead of rd_ptr while that word sits in the output slot.
        fifo_empty = (wr_ptr_q == rd_ptr_q);
        fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W])
                     && (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
        can_load   = (wr_ptr_q != ld_ptr_q);
        head       = fifo_q[ld_ptr_q[PTR_W-1:0]];
        slot_free  = !text_enable_q || bus.text_ready;
        pop        = text_enable_q && bus.text_ready && slot_fifo_q;

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        unique case (state_q)
            ST_FILL: begin
                if (slot_free) begin
                    if (fill_left_q != '0) begin
                        text_enable_d = 1'b1;
                        slot_fifo_d   = 1'b0;
                        text_addr_d   = fill_addr_q;
                        text_data_d   = fill_word_q;
                        fill_addr_d   = fill_addr_q + ADDR_ONE;
                        fill_left_d   = fill_left_q - CNT_ONE;
                    end else if (can_load) begin
                        text_enable_d = 1'b1;
                        slot_fifo_d   = 1'b1;
                        text_addr_d   = head.addr;
                        text_data_d   = head.data;
                        ld_ptr_d      = ld_ptr_q + PTR_ONE;
                        state_d       = ST_DRAIN;
                    end else begin
                        text_enable_d = 1'b0;
                        slot_fifo_d   = 1'b0;
                        state_d       = ST_IDLE;
                    end
                end
            end
            default: begin
                if (cmd_valid) begin
                    // A word already in the slot finishes; no new FIFO word is loaded.
                    state_d     = ST_FILL;
                    fill_word_d = {attr_q, fillchar_q};
                    if (bus.data_in == CMD_CLEAR) begin
                        fill_addr_d = '0;
                        fill_left_d = SCREEN_WORDS;
                        cur_x_d     = '0;
                        cur_y_d     = '0;
                    end else begin
                        fill_addr_d = cursor_addr;
                        fill_left_d = CNT_W'(COLS) - CNT_W'(cur_x_q);
                    end
                    if (slot_free) begin
                        text_enable_d = 1'b0;
                        slot_fifo_d   = 1'b0;
                    end
                end else if (slot_free) begin
                    if (can_load) begin
                        text_enable_d = 1'b1;
                        slot_fifo_d   = 1'b1;
                        text_addr_d   = head.addr;
                        text_data_d   = head.data;
                        ld_ptr_d      = ld_ptr_q + PTR_ONE;
                        state_d       = ST_DRAIN;
                    end else begin
                        text_enable_d = 1'b0;
                        slot_fifo_d   = 1'b0;
                        state_d       = ST_IDLE;
                    end
                end
            end
        endcase

        // A transfer on a full FIFO frees the slot the new entry takes
        push_ok = !fifo_full || pop;

        if (wr_access) begin
            unique case (bus.addr)
                REG_ATTR:     attr_d     = bus.data_in;
                REG_FILLCHAR: fillchar_d = bus.data_in;
                REG_CUR_X:    cur_x_d    = (bus.data_in > COLS_M1) ? COLS_M1 : bus.data_in;
                REG_CUR_Y:    cur_y_d    = (bus.data_in > ROWS_M1) ? ROWS_M1 : bus.data_in;
                REG_CHAR: begin
                    char_d = bus.data_in;
                    if (push_ok) begin
                        fifo_d[wr_ptr_q[PTR_W-1:0]] = '{addr: cursor_addr,
                                                        data: {attr_q, bus.data_in}};
                        wr_ptr_d = wr_ptr_q + PTR_ONE;
                    end else begin
                        overflow_d = 1'b1;
                    end
                    if (cur_x_q == COLS_M1) begin
                        cur_x_d = '0;
                        cur_y_d = (cur_y_q == ROWS_M1) ? 8'd0 : cur_y_q + 8'd1;
                    end else begin
                        cur_x_d = cur_x_q + 8'd1;
                    end
                end
                default: ;
            endcase
        end

        if (rd_access) begin
            unique case (bus.addr)
                REG_ATTR:     data_out_d = attr_q;
                REG_CHAR:     data_out_d = char_q;
                REG_FILLCHAR: data_out_d = fillchar_q;
                REG_CUR_X:    data_out_d = cur_x_q;
                REG_CUR_Y:    data_out_d = cur_y_q;
                REG_STATUS: begin
                    data_out_d = {4'b0000, fifo_empty, overflow_q, fifo_full,
                                  (state_q == ST_FILL)};
                    overflow_d = 1'b0;
                end
                default:      data_out_d = 8'h00;
            endcase
        end
    end

    // State register with synchronous reset
    always_ff @(posedge cpu_clock) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            attr_q        <= '0;
            char_q        <= '0;
            fillchar_q    <= '0;
            cur_x_q       <= '0;
            cur_y_q       <= '0;
            overflow_q    <= 1'b0;
            data_out_q    <= '0;
            text_addr_q   <= '0;
            text_data_q   <= '0;
            text_enable_q <= 1'b0;
            slot_fifo_q   <= 1'b0;
            fill_addr_q   <= '0;
            fill_left_q   <= '0;
            fill_word_q   <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            ld_ptr_q      <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            attr_q        <= attr_d;
            char_q        <= char_d;
            fillchar_q    <= fillchar_d;
            cur_x_q       <= cur_x_d;
            cur_y_q       <= cur_y_d;
            overflow_q    <= overflow_d;
            data_out_q    <= data_out_d;
            text_addr_q   <= text_addr_d;
            text_data_q   <= text_data_d;
            text_enable_q <= text_enable_d;
            slot_fifo_q   <= slot_fifo_d;
            fill_addr_q   <= fill_addr_d;
            fill_left_q   <= fill_left_d;
            fill_word_q   <= fill_word_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            ld_ptr_q      <= ld_ptr_d;
            fifo_q        <= fifo_d;
        end
    end

endmodule

// File: tb/tb_text_cmd_engine.sv
// Directed bench for text_cmd_engine (80x30 screen, 12-bit address, 4-deep FIFO).
module tb_text_cmd_engine;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    text_cmd_engine_if #(.ADDR_W(12)) bus ();

    text_cmd_engine #(
        .COLS       (80),
        .ROWS       (30),
        .ADDR_W     (12),
        .FIFO_DEPTH (4)
    ) dut (
        .cpu_clock (clk),
        .reset     (reset),
        .bus       (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // {addr[11:0], data[15:0]} of every word the text memory accepts
    logic [27:0] xq[$];

    // Log transfers mid-cycle; inputs settle 2 ns after each rising edge
    always @(negedge clk) begin
        if (!reset && bus.text_enable && bus.text_ready) begin
            xq.push_back({bus.text_addr, bus.text_data});
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic cpu_wr(input logic [3:0] a, input logic [7:0] d);
        bus.ce      = 1'b1;
        bus.rw      = 1'b1;
        bus.addr    = a;
        bus.data_in = d;
        step();
        bus.ce = 1'b0;
        bus.rw = 1'b0;
    endtask

    task automatic cpu_rd_chk(input string tag, input logic [3:0] a, input logic [7:0] exp);
        bus.ce   = 1'b1;
        bus.rw   = 1'b0;
        bus.addr = a;
        step();
        bus.ce = 1'b0;
        check(tag, 32'(bus.data_out), 32'(exp));
    endtask

    task automatic wait_xfers(input int n, input int budget);
        int k = 0;
        while (xq.size() < n && k < budget) begin
            step();
            k++;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int bad;
        int k;

        reset          = 1'b1;
        bus.ce         = 1'b0;
        bus.rw         = 1'b0;
        bus.addr       = '0;
        bus.data_in    = '0;
        bus.text_ready = 1'b1;
        step();
        step();
        reset = 1'b0;

        // Reset state
        check("rst_enable",   32'(bus.text_enable), 32'd0);
        check("rst_addr",     32'(bus.text_addr),   32'd0);
        check("rst_data",     32'(bus.text_data),   32'd0);
        check("rst_data_out", 32'(bus.data_out),    32'd0);
        cpu_rd_chk("rst_status", 4'd6, 8'h08);

        // Single CHAR write at (20,15)
        cpu_wr(4'd0, 8'h1E);
        cpu_wr(4'd3, 8'd20);
        cpu_wr(4'd4, 8'd15);
        cpu_wr(4'd1, 8'hA2);
        step();
        check("char_lat_en",   32'(bus.text_enable), 32'd1);
        check("char_lat_addr", 32'(bus.text_addr),   32'd1220);
        check("char_lat_data", 32'(bus.text_data),   32'h1EA2);
        wait_xfers(1, 20);
        repeat (3) step();
        check("char_count", 32'(xq.size()), 32'd1);
        if (xq.size() >= 1) check("char_word", 32'(xq[0]), {4'h0, 12'd1220, 16'h1EA2});
        cpu_rd_chk("char_curx", 4'd3, 8'd21);
        cpu_rd_chk("char_read", 4'd1, 8'hA2);
        cpu_rd_chk("fill_rd0",  4'd7, 8'h00);

        // Clamp and wrap to top-left
        cpu_wr(4'd3, 8'd200);
        cpu_rd_chk("clamp_x", 4'd3, 8'd79);
        cpu_wr(4'd4, 8'd255);
        cpu_rd_chk("clamp_y", 4'd4, 8'd29);
        xq.delete();
        cpu_wr(4'd1, 8'h41);
        cpu_wr(4'd1, 8'h41);
        wait_xfers(2, 20);
        repeat (3) step();
        check("wrap_count", 32'(xq.size()), 32'd2);
        if (xq.size() >= 2) begin
            check("wrap_w0", 32'(xq[0]), {4'h0, 12'd2399, 16'h1E41});
            check("wrap_w1", 32'(xq[1]), {4'h0, 12'd0,    16'h1E41});
        end
        cpu_rd_chk("wrap_curx", 4'd3, 8'd1);
        cpu_rd_chk("wrap_cury", 4'd4, 8'd0);

        // Overflow with memory stalled
        cpu_wr(4'd3, 8'd0);
        xq.delete();
        bus.text_ready = 1'b0;
        for (int i = 0; i < 5; i++) cpu_wr(4'd1, 8'(8'h61 + i));
        cpu_rd_chk("ovf_status",  4'd6, 8'h06);
        cpu_rd_chk("ovf_cleared", 4'd6, 8'h02);
        check("ovf_stall_none", 32'(xq.size()), 32'd0);
        bus.text_ready = 1'b1;
        wait_xfers(4, 20);
        repeat (3) step();
        check("ovf_count", 32'(xq.size()), 32'd4);
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            if (i < xq.size() && xq[i] !== {12'(i), 8'h1E, 8'(8'h61 + i)}) bad++;
        end
        check("ovf_order_bad", 32'(bad), 32'd0);
        cpu_rd_chk("ovf_status_end", 4'd6, 8'h08);
        cpu_rd_chk("ovf_curx", 4'd3, 8'd5);

        // Clear screen, with an ignored CMD and a CHAR queued during the fill
        cpu_wr(4'd2, 8'h20);
        cpu_wr(4'd0, 8'h07);
        xq.delete();
        cpu_wr(4'd5, 8'h01);
        cpu_rd_chk("clr_busy", 4'd6, 8'h09);
        cpu_wr(4'd5, 8'h02);
        cpu_wr(4'd1, 8'h58);
        wait_xfers(2401, 3000);
        repeat (10) step();
        check("clr_count", 32'(xq.size()), 32'd2401);
        bad = 0;
        for (int i = 0; i < 2400; i++) begin
            if (i < xq.size() && xq[i] !== {12'(i), 16'h0720}) bad++;
        end
        check("clr_seq_bad", 32'(bad), 32'd0);
        if (xq.size() >= 2401) check("clr_char_after", 32'(xq[2400]), {4'h0, 12'd0, 16'h0758});
        cpu_rd_chk("clr_idle", 4'd6, 8'h08);
        cpu_rd_chk("clr_fillchar", 4'd2, 8'h20);
        cpu_rd_chk("clr_curx", 4'd3, 8'd1);

        // Clear to end of line from (70,3)
        cpu_wr(4'd3, 8'd70);
        cpu_wr(4'd4, 8'd3);
        xq.delete();
        cpu_wr(4'd5, 8'h02);
        wait_xfers(10, 60);
        repeat (5) step();
        check("eol_count", 32'(xq.size()), 32'd10);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (i < xq.size() && xq[i] !== {12'(310 + i), 16'h0720}) bad++;
        end
        check("eol_seq_bad", 32'(bad), 32'd0);
        cpu_rd_chk("eol_curx", 4'd3, 8'd70);
        cpu_rd_chk("eol_cury", 4'd4, 8'd3);

        // Reset in the middle of a clear
        xq.delete();
        cpu_wr(4'd5, 8'h01);
        k = 0;
        while (xq.size() < 100 && k < 300) begin
            step();
            k++;
        end
        check("mid_reached", 32'(xq.size()), 32'd100);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_rst_enable", 32'(bus.text_enable), 32'd0);
        check("mid_rst_addr",   32'(bus.text_addr),   32'd0);
        repeat (3) step();
        check("mid_rst_count", 32'(xq.size()), 32'd100);
        cpu_rd_chk("mid_rst_status", 4'd6, 8'h08);
        cpu_rd_chk("mid_rst_attr",   4'd0, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/text_cmd_engine.md
# text_cmd_engine

Parametrised successor to the CPU-facing text command port: accepts byte-wide register writes from the host CPU bus and turns them into 16-bit character/attribute writes into text memory. Adds configurable screen geometry, a write FIFO with a ready/enable handshake toward text memory, cursor auto-advance with wrap, and a hardware fill engine for clear-screen and clear-to-end-of-line. Sits between the CPU bus decoder and the text RAM write port.

## Interface
- COLS, 80, characters per row (2..255)
- ROWS, 30, rows per screen (2..255)
- ADDR_W, 12, text address width; COLS*ROWS must be <= 2**ADDR_W
- FIFO_DEPTH, 4, write FIFO entries (power of two, >= 2)
- cpu_clock  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- ce  in  1  register access strobe, sampled each rising edge
- rw  in  1  1 = write, 0 = read
- addr  in  4  register select
- data_in  in  8  write data
- data_out  out  8  read data, registered
- text_addr  out  ADDR_W  text memory word address
- text_data  out  16  {attr[7:0], char[7:0]}
- text_enable  out  1  write strobe, one word per cycle
- text_ready  in  1  text memory accepts the word while high

## Operation
- Registers (write when ce&rw, read when ce&!rw): 0 ATTR; 1 CHAR (write: enqueue {ATTR,data_in} at cursor, then advance cursor; read: last char written); 2 FILLCHAR; 3 CUR_X; 4 CUR_Y; 5 CMD (write only); 6 STATUS (read: bit0 busy, bit1 fifo_full, bit2 overflow, bit3 fifo_empty); others read 0x00, writes ignored.
- Cursor address = CUR_Y*COLS + CUR_X, computed at enqueue time and stored in the FIFO entry; later cursor writes never affect queued entries.
- Advance: X+1; if X==COLS-1 then X=0, Y+1; if also Y==ROWS-1 then Y=0 (wrap to top-left).
- CUR_X/CUR_Y writes clamp: value >= COLS (ROWS) stores COLS-1 (ROWS-1).
- CMD 0x01 CLEAR: fill all COLS*ROWS words with {ATTR,FILLCHAR} from address 0 upward; cursor set to 0,0 on command accept. CMD 0x02 EOL: fill from cursor address to end of current row; cursor unchanged. Other CMD values ignored.
- States: IDLE, DRAIN (FIFO non-empty), FILL. IDLE->FILL on valid CMD; IDLE->DRAIN when FIFO non-empty; FILL->IDLE/DRAIN after last fill word accepted. Fill has priority: FIFO entries wait until FILL completes.
- CMD written while busy: ignored. CHAR write while FIFO full: dropped, overflow set (sticky); overflow cleared by a STATUS read. Cursor still advances on a dropped write.
- ATTR/FILLCHAR captured into the fill engine on command accept; later writes do not alter a running fill.

## Timing
- Reset values: data_out 0x00, text_addr 0, text_data 0, text_enable 0, all registers 0, FIFO empty, overflow 0, state IDLE.
- Reset mid-fill or with FIFO non-empty: operation aborted, FIFO discarded, text_enable low on the next cycle.
- Read: data_out valid the cycle after the edge sampling ce&!rw; holds until the next read.
- CHAR write at edge N: earliest text_enable at edge N+1 (text_enable/addr/data registered outputs).
- Handshake: word transfers on an edge where text_enable&text_ready; outputs hold stable while text_enable&!text_ready.
- Throughput: one word per cycle while text_ready high, for both FIFO drain and fill.
- Busy (STATUS bit0) high from the edge after CMD accept until the cycle after the last fill word transfers.
- Simultaneous enqueue and dequeue on a full FIFO: enqueue accepted, no overflow.

## Test plan
- Reset, write ATTR=0x1E, CUR_X=20, CUR_Y=15, CHAR=0xA2 -> one text_enable, text_addr=1220, text_data=0x1EA2; CUR_X reads 21.
- CUR_X=79, CUR_Y=29, write CHAR 0x41 twice -> addrs 2399 then 0; cursor reads 1,0.
- Hold text_ready=0, write CHAR 5 times (FIFO_DEPTH=4) -> STATUS=0x06; release ready -> 4 words in order; STATUS read clears overflow.
- FILLCHAR=0x20, ATTR=0x07, CMD=0x01 -> 2400 consecutive words 0..2399 of 0x0720, busy drops after last; CHAR written during fill lands at addr 0 after fill.
- CUR_X=70, CUR_Y=3, CMD=0x02 -> words at addrs 310..319 only; cursor still 70,3.
- Assert reset mid-CLEAR at word 100 -> text_enable 0 next cycle, STATUS reads 0x08.
